// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcodes, flag bit positions and control state for alu_pipe.
package alu_pipe_pkg;
   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_INC = 4'd2, OP_DEC = 4'd3,
                          OP_INCB = 4'd4, OP_DECB = 4'd5, OP_CMP = 4'd6, OP_ADC = 4'd7,
                          OP_SBB = 4'd8, OP_MUL = 4'd9;
   localparam logic [3:0] L_AND = 4'd0, L_OR = 4'd1, L_XOR = 4'd2, L_NOTA = 4'd3,
                          L_NOTB = 4'd4, L_SHLA = 4'd5, L_SHRA = 4'd6, L_SHLB = 4'd7,
                          L_SHRB = 4'd8, L_NAND = 4'd9, L_NOR = 4'd10, L_XNOR = 4'd11,
                          L_ROL = 4'd12, L_ROR = 4'd13;
   localparam int FLG_C = 0, FLG_V = 1, FLG_Z = 2, FLG_N = 3,
                  FLG_EQ = 4, FLG_GT = 5, FLG_LT = 6, FLG_ERR = 7;
   typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/alu_pipe_mul.sv
// alu_pipe_mul: iterative shift-add unsigned multiplier, one step per clock,
// used by alu_pipe when ALU_PIPE_MUL_EN is defined.
module alu_pipe_mul #(
   parameter int WIDTH = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic               o_done,
   output logic [2*WIDTH-1:0] o_product
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   logic [2*WIDTH-1:0] r_p;
   logic [WIDTH-1:0]   r_m;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH:0]     w_sum;
   // Low half holds the unconsumed multiplier bits; done/product expose the final step combinationally
   assign w_sum     = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_m} : '0);
   assign o_product = {w_sum, r_p[WIDTH-1:1]};
   assign o_done    = (r_cnt == CNT_W'(1));
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_p   <= '0;
         r_m   <= '0;
         r_cnt <= '0;
      end else if (i_start) begin
         r_p   <= {{WIDTH{1'b0}}, i_b};
         r_m   <= i_a;
         r_cnt <= CNT_W'(WIDTH);
      end else if (r_cnt != '0) begin
         r_p   <= o_product;
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: WIDTH-generic ALU with valid/ready handshakes, carry chain and flag byte.
// Define ALU_PIPE_MUL_EN to enable the iterative multiplier; otherwise MUL is an ERR op.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_mode,
   input  logic [3:0]       i_cmd,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_res,
   output logic [WIDTH-1:0] o_res_hi,
   output logic [7:0]       o_flag
);
   localparam int CNT_W = $clog2(WIDTH + 1);
   state_t             r_state;
   logic               r_valid, r_carry;
   logic [WIDTH-1:0]   r_res, r_res_hi;
   logic [7:0]         r_flag;
   logic [WIDTH-1:0]   w_x, w_y, w_lres, w_res, w_rol, w_ror;
   logic [2*WIDTH-1:0] w_rl2, w_rr2;
   logic [CNT_W-1:0]   w_amt;
   logic [WIDTH:0]     w_sum;
   logic               w_cin, w_sub, w_arith, w_upd, w_cmp, w_err, w_mul, w_lc, w_c, w_v, w_acc;
   logic [7:0]         w_flag;
   assign o_in_ready  = i_rst_n && (r_state == IDLE) && (!r_valid || i_out_ready);
   assign o_out_valid = r_valid;
   assign o_res       = r_res;
   assign o_res_hi    = r_res_hi;
   assign o_flag      = r_flag;
   assign w_acc       = i_in_valid && o_in_ready;
   assign w_amt       = CNT_W'(32'(i_b[CNT_W-2:0]) % WIDTH);
   assign w_rl2       = {i_a, i_a} << w_amt;
   assign w_rr2       = {i_a, i_a} >> w_amt;
   assign w_rol       = w_rl2[2*WIDTH-1:WIDTH];
   assign w_ror       = w_rr2[WIDTH-1:0];
   always_comb begin
      w_x = i_a;
      w_y = i_b;
      w_cin = 1'b0;
      w_sub = 1'b0;
      w_arith = i_mode;
      w_upd = i_mode;
      w_cmp = 1'b0;
      w_err = 1'b0;
      w_mul = 1'b0;
      w_lres = '0;
      w_lc = 1'b0;
      if (i_mode)
         case (i_cmd)
            OP_ADD: w_sub = 1'b0;
            OP_SUB: w_sub = 1'b1;
            OP_INC: w_y = WIDTH'(1);
            OP_DEC: begin w_y = WIDTH'(1); w_sub = 1'b1; end
            OP_INCB: begin w_x = i_b; w_y = WIDTH'(1); end
            OP_DECB: begin w_x = i_b; w_y = WIDTH'(1); w_sub = 1'b1; end
            OP_CMP: begin w_sub = 1'b1; w_upd = 1'b0; w_cmp = 1'b1; end
            OP_ADC: w_cin = r_carry;
            OP_SBB: begin w_sub = 1'b1; w_cin = r_carry; end
`ifdef ALU_PIPE_MUL_EN
            OP_MUL: begin w_mul = 1'b1; w_upd = 1'b0; end
`endif
            default: begin w_err = 1'b1; w_upd = 1'b0; end
         endcase
      else
         case (i_cmd)
            L_AND:  w_lres = i_a & i_b;
            L_OR:   w_lres = i_a | i_b;
            L_XOR:  w_lres = i_a ^ i_b;
            L_NOTA: w_lres = ~i_a;
            L_NOTB: w_lres = ~i_b;
            L_SHLA: begin w_lres = i_a << 1; w_lc = i_a[WIDTH-1]; end
            L_SHRA: begin w_lres = i_a >> 1; w_lc = i_a[0]; end
            L_SHLB: begin w_lres = i_b << 1; w_lc = i_b[WIDTH-1]; end
            L_SHRB: begin w_lres = i_b >> 1; w_lc = i_b[0]; end
            L_NAND: w_lres = ~(i_a & i_b);
            L_NOR:  w_lres = ~(i_a | i_b);
            L_XNOR: w_lres = ~(i_a ^ i_b);
            L_ROL:  w_lres = w_rol;
            L_ROR:  w_lres = w_ror;
            default: w_err = 1'b1;
         endcase
   end
   // Bit WIDTH of the widened sum is carry for adds and borrow for subtracts
   assign w_sum = w_sub ? {1'b0, w_x} - {1'b0, w_y} - {{WIDTH{1'b0}}, w_cin}
                        : {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
   assign w_v   = w_arith && ((w_x[WIDTH-1] ^ w_y[WIDTH-1]) == w_sub) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
   assign w_c   = w_arith ? w_sum[WIDTH] : w_lc;
   assign w_res = w_err ? '0 : w_arith ? w_sum[WIDTH-1:0] : w_lres;
   always_comb begin
      w_flag = '0;
      w_flag[FLG_ERR] = w_err;
      w_flag[FLG_C] = !w_err && w_c;
      w_flag[FLG_V] = !w_err && w_v;
      w_flag[FLG_Z] = !w_err && (w_res == '0);
      w_flag[FLG_N] = !w_err && w_res[WIDTH-1];
      w_flag[FLG_EQ] = w_cmp && (i_a == i_b);
      w_flag[FLG_GT] = w_cmp && (i_a > i_b);
      w_flag[FLG_LT] = w_cmp && (i_a < i_b);
   end
`ifdef ALU_PIPE_MUL_EN
   logic               w_mul_done;
   logic [2*WIDTH-1:0] w_prod;
   logic [7:0]         w_mflag;
   alu_pipe_mul #(.WIDTH(WIDTH)) u_mul (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(w_acc && w_mul),
      .i_a(i_a), .i_b(i_b), .o_done(w_mul_done), .o_product(w_prod)
   );
   always_comb begin
      w_mflag = '0;
      w_mflag[FLG_C] = |w_prod[2*WIDTH-1:WIDTH];
      w_mflag[FLG_V] = |w_prod[2*WIDTH-1:WIDTH];
      w_mflag[FLG_Z] = (w_prod == '0);
      w_mflag[FLG_N] = w_prod[2*WIDTH-1];
   end
`endif
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_valid  <= 1'b0;
         r_carry  <= 1'b0;
         r_res    <= '0;
         r_res_hi <= '0;
         r_flag   <= '0;
      end else begin
         if (w_acc && !w_mul) begin
            r_res    <= w_res;
            r_res_hi <= '0;
            r_flag   <= w_flag;
            r_valid  <= 1'b1;
            if (w_upd) r_carry <= w_c;
`ifdef ALU_PIPE_MUL_EN
         end else if (r_state == BUSY && w_mul_done) begin
            r_res    <= w_prod[WIDTH-1:0];
            r_res_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_flag   <= w_mflag;
            r_valid  <= 1'b1;
            r_state  <= IDLE;
`endif
         end else if (r_valid && i_out_ready) begin
            r_valid <= 1'b0;
         end
         if (w_acc && w_mul) r_state <= BUSY;
      end
   end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random checks of alu_pipe against an integer reference model.
module tb_alu_pipe;
   localparam int W = 8;
   logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, mode = 1'b0;
   logic [3:0]   cmd = '0;
   logic [W-1:0] a = '0, b = '0;
   logic         in_ready, out_valid;
   logic [W-1:0] res, res_hi;
   logic [7:0]   flag;
   int           n_chk = 0, n_pass = 0, cy = 0;

   alu_pipe #(.WIDTH(W)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_a(a), .i_b(b), .i_mode(mode), .i_cmd(cmd), .o_out_valid(out_valid),
      .i_out_ready(out_ready), .o_res(res), .o_res_hi(res_hi), .o_flag(flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic int sg(input int x);
      return x > 127 ? x - 256 : x;
   endfunction

   function automatic void model(input int m, input int c, input int ai, input int bi, input int ci,
                                 output int r, output int hi, output int f, output int nc, output bit mul);
      int u, s, amt;
      bit ar, upd, cmpf, err, cf, vf;
      u = 0; s = 0; ar = m != 0; upd = 0; cmpf = 0; err = 0; cf = 0; vf = 0; hi = 0; mul = 0; r = 0;
      amt = bi % 8;
      if (ar) begin
         upd = 1;
         case (c)
            0: begin u = ai + bi; s = sg(ai) + sg(bi); end
            1: begin u = ai - bi; s = sg(ai) - sg(bi); end
            2: begin u = ai + 1; s = sg(ai) + 1; end
            3: begin u = ai - 1; s = sg(ai) - 1; end
            4: begin u = bi + 1; s = sg(bi) + 1; end
            5: begin u = bi - 1; s = sg(bi) - 1; end
            6: begin u = ai - bi; s = sg(ai) - sg(bi); upd = 0; cmpf = 1; end
            7: begin u = ai + bi + ci; s = sg(ai) + sg(bi) + ci; end
            8: begin u = ai - bi - ci; s = sg(ai) - sg(bi) - ci; end
`ifdef ALU_PIPE_MUL_EN
            9: begin mul = 1; upd = 0; end
`endif
            default: begin err = 1; upd = 0; end
         endcase
         r = u & 255; cf = (u > 255) || (u < 0); vf = (s > 127) || (s < -128);
      end else
         case (c)
            0: r = ai & bi;
            1: r = ai | bi;
            2: r = ai ^ bi;
            3: r = ~ai & 255;
            4: r = ~bi & 255;
            5: begin r = (ai * 2) & 255; cf = ai >= 128; end
            6: begin r = ai / 2; cf = ai % 2; end
            7: begin r = (bi * 2) & 255; cf = bi >= 128; end
            8: begin r = bi / 2; cf = bi % 2; end
            9: r = ~(ai & bi) & 255;
            10: r = ~(ai | bi) & 255;
            11: r = ~(ai ^ bi) & 255;
            12: r = ((ai << amt) | (ai >> (8 - amt))) & 255;
            13: r = ((ai >> amt) | (ai << (8 - amt))) & 255;
            default: err = 1;
         endcase
      if (mul) begin
         u = ai * bi; r = u % 256; hi = u / 256;
         f = (hi != 0 ? 3 : 0) + (u == 0 ? 4 : 0) + (hi >= 128 ? 8 : 0);
      end else if (err) begin
         r = 0; f = 128;
      end else
         f = cf + 2 * vf + 4 * (r == 0) + 8 * (r >= 128) +
             (cmpf ? 16 * (ai == bi) + 32 * (ai > bi) + 64 * (ai < bi) : 0);
      nc = upd ? int'(cf) : ci;
   endfunction

   task automatic do_op(input logic m, input logic [3:0] c, input logic [7:0] ai, input logic [7:0] bi);
      int er, eh, ef, ec;
      bit mul;
      @(negedge clk);
      mode = m; cmd = c; a = ai; b = bi; in_valid = 1'b1; out_ready = 1'b1;
      #1 chk("in_ready", in_ready, 1);
      model(m, c, ai, bi, cy, er, eh, ef, ec, mul);
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (mul)
         for (int i = 0; i < W; i++) begin
            chk("busy_ready", in_ready, 0);
            chk("busy_valid", out_valid, 0);
            @(posedge clk);
            #1;
         end
      chk("out_valid", out_valid, 1);
      chk("res", res, er);
      chk("res_hi", res_hi, eh);
      chk("flag", flag, ef);
      cy = ec;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_res", res, 0);
      chk("rst_flag", flag, 0);
      chk("rst_ready", in_ready, 0);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("ready_after_rst", in_ready, 1);

      do_op(1, 0, 8'hFF, 8'h01);
      chk("add_ff_res", res, 8'h00);
      chk("add_ff_flag", flag, 8'h05);
      do_op(1, 7, 8'h00, 8'h00);
      chk("adc_res", res, 8'h01);
      chk("adc_flag", flag, 8'h00);
      do_op(1, 0, 8'h7F, 8'h01);
      chk("add_ovf_flag", flag, 8'h0A);
      do_op(0, 4'hF, 8'h12, 8'h34);
      chk("err_flag", flag, 8'h80);
      do_op(1, 2, 8'hFF, 8'h00);
      do_op(1, 3, 8'h00, 8'h00);
      do_op(1, 6, 8'h10, 8'h20);
      do_op(1, 8, 8'h00, 8'h7F);
      do_op(1, 9, 8'hFF, 8'hFF);
`ifdef ALU_PIPE_MUL_EN
      chk("mul_hi", res_hi, 8'hFE);
      chk("mul_lo", res, 8'h01);
`else
      chk("mul_off_flag", flag, 8'h80);
`endif

      for (int i = 0; i < 200; i++)
         do_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

      // Backpressure: hold the first result while a second op waits
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      mode = 1'b1; cmd = 4'd0; a = 8'd3; b = 8'd4; in_valid = 1'b1; out_ready = 1'b0;
      #1 chk("bp_ready0", in_ready, 1);
      @(posedge clk);
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_res1", res, 8'd7);
      cmd = 4'd1; a = 8'd9; b = 8'd1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_stall_ready", in_ready, 0);
         chk("bp_frozen", res, 8'd7);
         chk("bp_hold_valid", out_valid, 1);
      end
      @(negedge clk) out_ready = 1'b1;
      #1 chk("bp_ready1", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_res2", res, 8'd8);
      chk("bp_valid2", out_valid, 1);
      cy = 0;

      // Reset while a MUL (or its ERR stand-in) is outstanding
      @(negedge clk);
      mode = 1'b1; cmd = 4'd9; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_flag", flag, 0);
      chk("midrst_ready", in_ready, 0);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("midrst_ready1", in_ready, 1);
      cy = 0;
      repeat (W + 2) begin
         @(posedge clk);
         #1 chk("no_late_mul", out_valid, 0);
      end
      do_op(1, 7, 8'h01, 8'h01);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised successor of the team's single-cycle 8-bit ALU. It has a WIDTH-generic datapath, valid/ready handshakes on input and output, and a fully defined flag byte recomputed on every operation. It adds a carry-chain register for multi-word add/subtract and an optional iterative shift-add multiplier. It sits between the command sequencer and the result writeback, and stalls under output backpressure.

Parameters:
WIDTH, 8, operand and result width (>=4)
CNT_W, $clog2(WIDTH+1), multiplier iteration counter width (derived, not overridden)

Ports:
CLK  in  1  clock
RST_N  in  1  reset; one clock, reset synchronous active-low
IN_VALID  in  1  command/operands valid
IN_READY  out  1  block accepts command this cycle
A  in  WIDTH  operand A
B  in  WIDTH  operand B
MODE  in  1  1 = arithmetic, 0 = logical
CMD  in  4  opcode
OUT_VALID  out  1  RES/RES_HI/FLAG valid
OUT_READY  in  1  downstream consumes result
RES  out  WIDTH  result (low half for MUL)
RES_HI  out  WIDTH  high half of MUL product; 0 for all other ops
FLAG  out  8  [0]C [1]V [2]Z [3]N [4]EQ [5]GT [6]LT [7]ERR

Behaviour:
- Reset (RST_N=0 at posedge):
  - OUT_VALID=0, RES=0, RES_HI=0, FLAG=0, carry register CARRY_Q=0, state=IDLE, counter=0.
  - IN_READY=0 while RST_N=0.
  - Reset mid-multiply aborts the multiply with no output.
- States:
  - IDLE: no multiply in flight.
  - BUSY: multiply iterating.
  - IN_READY = (state==IDLE) && (!OUT_VALID || OUT_READY).
- Accept = IN_VALID && IN_READY at posedge.
- Output consumed = OUT_VALID && OUT_READY at posedge. OUT_VALID clears unless a new single-cycle result loads on the same edge.
- Single-cycle op accepted at edge k: RES/FLAG registered at edge k, so OUT_VALID=1 after edge k (latency 1). Throughput is 1/cycle while OUT_READY=1.
- Output hold: while OUT_VALID && !OUT_READY, RES/RES_HI/FLAG are frozen and no accept occurs.
- Arithmetic (MODE=1):
  - 0 ADD A+B; 1 SUB A-B; 2 INC A; 3 DEC A; 4 INC B; 5 DEC B.
  - 6 CMP: RES=A-B, CARRY_Q unchanged.
  - 7 ADC A+B+CARRY_Q; 8 SBB A-B-CARRY_Q.
  - 9 MUL (see feature); 10-15 ERR.
- Logical (MODE=0):
  - 0 AND; 1 OR; 2 XOR; 3 ~A; 4 ~B; 5 A<<1; 6 A>>1; 7 B<<1; 8 B>>1.
  - 9 NAND; 10 NOR; 11 XNOR.
  - 12 ROL A by B[CNT_W-2:0] mod WIDTH; 13 ROR likewise.
  - 14-15 ERR.
- Arithmetic computed at WIDTH+1 bits.
  - C = bit WIDTH (carry for add/inc, borrow for sub/dec/cmp/sbb).
  - V = signed two's-complement overflow.
  - CARRY_Q <= C on ADD/SUB/INC/DEC/ADC/SBB; unchanged by all other ops.
- Logical ops: C=V=0, except shifts, where C = the bit shifted out.
- Z = (RES==0); N = RES[WIDTH-1]; set for all valid ops.
- EQ/GT/LT: unsigned compare of A vs B, set only for CMP; otherwise 0.
- ERR op: RES=0, RES_HI=0, FLAG=8'h80, CARRY_Q unchanged, OUT_VALID asserted normally.
- Wrap-around: INC of all-ones gives 0, C=1. DEC of 0 gives all-ones, C=1.

Optional Feature:
- Macro ALU_PIPE_MUL_EN.
- Defined:
  - MUL is accepted at edge k; state goes to BUSY and counter=WIDTH.
  - One shift-add step per cycle; counter decrements each cycle.
  - At edge k+WIDTH: {RES_HI,RES} = unsigned A*B, state returns to IDLE, OUT_VALID=1.
  - Z = full product==0; N = RES_HI MSB; C = V = (RES_HI!=0).
  - IN_READY=0 throughout BUSY.
- Undefined: MUL is treated as ERR; BUSY is never entered.

Decomposition:
- Package alu_pipe_pkg:
  - opcode localparams for both modes;
  - flag bit index constants (FLG_C..FLG_ERR);
  - state enum {IDLE, BUSY}.
- Sub-module alu_pipe_mul, present only under ALU_PIPE_MUL_EN:
  - iterative shift-add engine;
  - ports start / done / product.

Test Plan:
- WIDTH=8, ADD A=8'hFF B=8'h01, OUT_READY=1 -> one cycle later RES=8'h00, FLAG=8'h05 (C,Z), CARRY_Q=1.
- Then ADC A=8'h00 B=8'h00 -> RES=8'h01, FLAG=8'h00; verifies carry chain.
- ADD A=8'h7F B=8'h01 -> RES=8'h80, FLAG=8'h0A (V,N).
- Backpressure:
  - Stimulus: OUT_READY=0 with IN_VALID held for 3 cycles.
  - Required: IN_READY=0 after first accept; RES frozen; second op accepted on the edge OUT_READY returns high.
- MUL with macro on, A=8'hFF B=8'hFF:
  - IN_READY low for 8 cycles.
  - Then RES_HI=8'hFE, RES=8'h01, FLAG C=V=1.
  - With macro off: FLAG=8'h80, RES=0.
- MODE=0 CMD=4'hF -> FLAG=8'h80.
- RST_N=0 during MUL BUSY -> next cycle OUT_VALID=0, FLAG=0, state IDLE, IN_READY=1 once RST_N=1.
